// File: rtl/dh_terminal_if.sv
// Parameter/result bundle between the C&C link controller and the terminal
// Diffie-Hellman engine.
interface dh_terminal_if #(
    parameter int W = 8
) ();
    logic         ena;
    logic         valid_in;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] A;
    logic [W-1:0] b;
    logic [W-1:0] B;
    logic [W-1:0] key;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output ena, valid_in, g, p, A, b,
        input  B, key, busy, done, err
    );

    modport slave (
        input  ena, valid_in, g, p, A, b,
        output B, key, busy, done, err
    );
endinterface

// File: rtl/dh_terminal.sv
// Terminal-side Diffie-Hellman responder: B = g^b mod p, key = A^b mod p,
// using one square-and-multiply datapath shared by both exponentiations.
//
// state  | meaning
// IDLE   | waiting for valid_in; inputs captured on accept
// LOAD_B | modulus check, seed datapath with g mod p
// EXP_B  | W constant-time square-and-multiply steps for B
// LOAD_K | publish B, seed datapath with A mod p
// EXP_K  | W steps for key, then one terminal-count cycle that publishes key
// DONE   | done pulse cycle, return to IDLE
module dh_terminal #(
    parameter int W = 8
) (
    input logic         clk,
    input logic         rst,
    dh_terminal_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        EXP_B,
        LOAD_K,
        EXP_K,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  g_r, p_r, a_r, b_r;
    logic [W-1:0]  res, base, e;
    logic [CW-1:0] cnt;
    logic [W-1:0]  b_out, key_r;
    logic          busy_r, done_r, err_r;
    logic [W-1:0]  res_nxt, base_nxt;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] m);
        return W'(({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, m});
    endfunction

    always_comb begin
        res_nxt  = res;
        base_nxt = mulmod(base, base, p_r);
        if (e[0]) res_nxt = mulmod(res, base, p_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            g_r    <= '0;
            p_r    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res    <= '0;
            base   <= '0;
            e      <= '0;
            cnt    <= '0;
            b_out  <= '0;
            key_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (bus.ena) begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        g_r    <= bus.g;
                        p_r    <= bus.p;
                        a_r    <= bus.A;
                        b_r    <= bus.b;
                        err_r  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (p_r < W'(2)) begin
                        // Bad modulus drains through the EXP_K terminal-count
                        // cycle so done lands exactly one edge after this one.
                        err_r <= 1'b1;
                        b_out <= '0;
                        key_r <= '0;
                        cnt   <= CW'(W);
                        state <= EXP_K;
                    end else begin
                        res   <= W'(1);
                        base  <= g_r % p_r;
                        e     <= b_r;
                        cnt   <= '0;
                        state <= EXP_B;
                    end
                end
                EXP_B: begin
                    res  <= res_nxt;
                    base <= base_nxt;
                    e    <= e >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) state <= LOAD_K;
                end
                LOAD_K: begin
                    b_out <= res;
                    res   <= W'(1);
                    base  <= a_r % p_r;
                    e     <= b_r;
                    cnt   <= '0;
                    state <= EXP_K;
                end
                EXP_K: begin
                    if (cnt == CW'(W)) begin
                        if (!err_r) key_r <= res;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        res  <= res_nxt;
                        base <= base_nxt;
                        e    <= e >> 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.B    = b_out;
    assign bus.key  = key_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_dh_terminal.sv
// Directed bench for dh_terminal: scoreboard of expected (B, key, err) per
// accepted run, plus edge-accurate latency and handshake checks.
module tb_dh_terminal;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dh_terminal_if #(.W(W)) dif ();
    dh_terminal #(.W(W)) dut (.clk(clk), .rst(rst), .bus(dif));

    typedef struct {
        logic [W-1:0] B;
        logic [W-1:0] key;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int   nchk  = 0;
    int   nfail = 0;

    function automatic logic [W-1:0] mexp(input logic [W-1:0] base,
                                          input logic [W-1:0] ex,
                                          input logic [W-1:0] m);
        logic [2*W-1:0] r;
        r = 1;
        for (int i = 0; i < int'(ex); i++) r = (r * base) % m;
        return r[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] g, input logic [W-1:0] p,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        x.err = (p < 2);
        x.B   = x.err ? '0 : mexp(g, b, p);
        x.key = x.err ? '0 : mexp(a, b, p);
        sbq.push_back(x);
    endtask

    task automatic check_out(input string tag);
        exp_t x;
        chk({tag, ".sb_pending"}, (sbq.size() > 0) ? 1 : 0, 1);
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk({tag, ".B"}, dif.B, x.B);
            chk({tag, ".key"}, dif.key, x.key);
            chk({tag, ".err"}, dif.err, x.err);
        end
    endtask

    task automatic set_in(input logic [W-1:0] g, input logic [W-1:0] p,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        dif.g = g;
        dif.p = p;
        dif.A = a;
        dif.b = b;
    endtask

    // Called just after an active edge. Edge 0 is the edge that accepts the run.
    task automatic run(input string tag, input logic [W-1:0] g, input logic [W-1:0] p,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int exp_edge,
                       input int glitch_edge, input int ena_edge, input int ena_len);
        int n;
        int busy_cycles;
        set_in(g, p, a, b);
        dif.valid_in = 1'b1;
        push_exp(g, p, a, b);
        @(posedge clk); #1;
        dif.valid_in = 1'b0;
        n = 0;
        busy_cycles = dif.busy ? 1 : 0;
        chk({tag, ".busy_rise"}, dif.busy, 1);
        chk({tag, ".err_clr"}, dif.err, 0);
        while (!dif.done && n < 200) begin
            if (n == glitch_edge - 1) begin
                dif.valid_in = 1'b1;
                set_in(g + 3, p + 10, a + 1, ~b);
            end else begin
                dif.valid_in = 1'b0;
            end
            if (n == ena_edge) dif.ena = 1'b0;
            if (n == ena_edge + ena_len) dif.ena = 1'b1;
            @(posedge clk); #1;
            n++;
            if (dif.busy) busy_cycles++;
        end
        dif.ena = 1'b1;
        dif.valid_in = 1'b0;
        chk({tag, ".done_edge"}, n, exp_edge);
        if (dif.done) check_out(tag);
        else if (sbq.size() > 0) sbq.delete(0);
        @(posedge clk); #1;
        chk({tag, ".done_fall"}, dif.done, 0);
        chk({tag, ".busy_fall"}, dif.busy, 0);
        chk({tag, ".busy_cycles"}, busy_cycles, exp_edge + 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        dif.ena = 1'b1;
        dif.valid_in = 1'b0;
        set_in('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.B", dif.B, 0);
        chk("reset.key", dif.key, 0);
        chk("reset.busy", dif.busy, 0);
        chk("reset.done", dif.done, 0);
        chk("reset.err", dif.err, 0);
        rst = 1'b0;

        run("nominal", 8'd5, 8'd23, 8'd8, 8'd15, 19, -1, -1, 0);
        run("zero_exp", 8'd5, 8'd23, 8'd8, 8'd0, 19, -1, -1, 0);
        run("reduce", 8'd30, 8'd23, 8'd30, 8'd1, 19, -1, -1, 0);
        run("wide_exp", 8'd200, 8'd251, 8'd77, 8'd255, 19, -1, -1, 0);
        run("bad_p", 8'd7, 8'd1, 8'd9, 8'd3, 2, -1, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bad_p.err_hold", dif.err, 1);
        run("after_bad", 8'd5, 8'd23, 8'd8, 8'd15, 19, -1, -1, 0);
        run("busy_valid", 8'd5, 8'd23, 8'd8, 8'd15, 19, 5, -1, 0);
        run("ena_freeze", 8'd5, 8'd23, 8'd8, 8'd15, 22, -1, 11, 3);

        // valid_in held high: second run accepted on the first IDLE cycle (edge 21)
        set_in(8'd5, 8'd23, 8'd8, 8'd15);
        dif.valid_in = 1'b1;
        push_exp(8'd5, 8'd23, 8'd8, 8'd15);
        @(posedge clk); #1;
        set_in(8'd9, 8'd0, 8'd4, 8'd4);
        push_exp(8'd9, 8'd0, 8'd4, 8'd4);
        n = 0;
        while (!dif.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held.first_edge", n, 19);
        if (dif.done) check_out("held.first");
        while (!(dif.done && n > 19) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        dif.valid_in = 1'b0;
        chk("held.second_edge", n, 23);
        if (dif.done) check_out("held.second");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held.idle", dif.busy, 0);

        run("pre_rst", 8'd5, 8'd23, 8'd8, 8'd15, 19, -1, -1, 0);

        // reset asserted mid-EXP_B, between clock edges
        set_in(8'd5, 8'd23, 8'd8, 8'd15);
        dif.valid_in = 1'b1;
        @(posedge clk); #1;
        dif.valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_run.busy", dif.busy, 1);
        rst = 1'b1;
        #1;
        chk("rst.B", dif.B, 0);
        chk("rst.key", dif.key, 0);
        chk("rst.busy", dif.busy, 0);
        chk("rst.done", dif.done, 0);
        chk("rst.err", dif.err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run("post_rst", 8'd5, 8'd23, 8'd8, 8'd15, 19, -1, -1, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/dh_terminal.md
# dh_terminal

Terminal-side Diffie-Hellman key-agreement engine, the responder to the C&C key initiator. The block accepts the public parameters g, p and the C&C public key A, plus the terminal's secret exponent b from its random generator. It computes the terminal public key B = g^b mod p and the shared key K = A^b mod p, using one iterative modular-exponentiation datapath reused for both results. B goes back to the C&C. K feeds the link cipher.

## Interface

Parameters:
- W, 8, width of g, p, A, b, B and key.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- ena, input, 1, clock enable; when low, every register holds its value.
- valid_in, input, 1, parameter strobe; sampled only in IDLE.
- g, input, W, generator from the C&C.
- p, input, W, modulus from the C&C.
- A, input, W, C&C public key.
- b, input, W, terminal secret exponent.
- B, output, W, terminal public key.
- key, output, W, shared secret.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when B and key are valid.
- err, output, 1, invalid modulus flag; valid with done.

## Operation

The block captures g, p, A and b into internal registers when valid_in is accepted. Input changes after that edge have no effect on the current computation.

State machine (IDLE, LOAD_B, EXP_B, LOAD_K, EXP_K, DONE):
- IDLE: if valid_in=1, capture the inputs and go to LOAD_B.
- LOAD_B:
  - If p<2: set err=1, B=0, key=0 and go to DONE.
  - Otherwise: res=1, base=g mod p, e=b, cnt=0, then go to EXP_B.
- EXP_B: one exponent bit per cycle, LSB first.
  - If e[0]=1: res = (res*base) mod p.
  - Always: base = (base*base) mod p, e = e>>1, cnt = cnt+1.
  - After exactly W steps, go to LOAD_K. There is no early exit even when e reaches 0 (constant-time requirement).
- LOAD_K: B=res; then res=1, base=A mod p, e=b (from the captured copy), cnt=0; go to EXP_K.
- EXP_K: same step as EXP_B; after W steps, go to DONE.
- DONE: key=res (skipped on the err path), done=1 for one cycle; go to IDLE.

Arithmetic rules:
- Products are 2W bits wide, reduced mod p to W bits.
- Reduction is combinational. Operands are always < p after the LOAD states.
- Inputs g ≥ p and A ≥ p are legal; they are reduced in the LOAD states.
- b=0 gives B=1 and key=1 when p≥2.

Boundary conditions:
- valid_in while busy=1: ignored, not queued.
- valid_in held high across DONE: a new run starts on the first IDLE cycle.
- ena=0 in any state: full freeze, and done stays asserted if the freeze happens in DONE.
- rst mid-run: immediate return to IDLE, and all outputs return to their reset values.
- err stays asserted from DONE until the next accepted valid_in, which clears it.
- B and key hold their values until overwritten by the next run, or zeroed on the err path.

## Timing

Reset values: B=0, key=0, busy=0, done=0, err=0, state=IDLE, all internal registers 0.

Latency, with edge 0 being the edge that samples valid_in=1 and ena=1 throughout:
- busy rises after edge 0.
- EXP_B steps occur on edges 2..W+1; B is written on edge W+2.
- EXP_K steps occur on edges W+3..2W+2.
- done and key are valid after edge 2W+3, which is edge 19 for W=8. done falls after edge 2W+4, together with busy.
- Err path: done is high after edge 2.
- Each cycle with ena=0 adds exactly one cycle of latency.
- Minimum spacing between accepted runs is 2W+5 edges.

## Test plan

- Nominal exchange: g=5, p=23, A=8, b=15, valid_in for one cycle -> done after edge 19, B=19, key=2, err=0; busy high for exactly 20 cycles.
- Zero exponent: g=5, p=23, A=8, b=0 -> B=1, key=1, done after edge 19.
- Operand reduction: g=30, p=23, A=30, b=1 -> B=7, key=7.
- Invalid modulus:
  - p=1, any g/A/b -> done after edge 2, err=1, B=0, key=0.
  - A following valid run with p=23 -> err=0 and correct results.
- Robustness: pulse valid_in again at edge 5 with different values -> ignored, results still B=19, key=2. Drop ena for 3 cycles during EXP_K -> done after edge 22, same results.
- Reset mid-run: assert rst during EXP_B -> B, key, busy, done and err are 0 immediately. After release, the nominal stimulus again gives B=19, key=2.
